// File: rtl/serializer.sv
// Parallel-in, serial-out transmitter: DATA_WIDTH-bit words in via valid/ready,
// out one bit per enabled cycle, LSB first, with a one-word holding register.
module serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_en,
    output logic                  o_data,
    output logic                  o_wen,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] hd_q, hd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  hold_full_q, hold_full_d;

    logic busy;
    logic accept;
    logic done;
    logic load;

    assign busy    = (state_q == SHIFT);
    assign o_ready = !i_rst && !hold_full_q;
    assign o_wen   = !i_rst && busy && i_en;
    assign o_data  = !i_rst && sh_q[0];
    assign o_last  = !i_rst && busy && (cnt_q == LAST_CNT);
    assign o_busy  = !i_rst && busy;

    assign accept = i_valid && o_ready;
    assign done   = o_wen && (cnt_q == LAST_CNT);
    // The shifter takes a new word when idle or on the edge its last bit leaves.
    assign load   = !busy || done;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hd_d        = hd_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;

        if (o_wen) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end

        if (load) begin
            if (hold_full_q) begin
                sh_d        = hd_q;
                cnt_d       = '0;
                state_d     = SHIFT;
                hold_full_d = 1'b0;
            end else if (accept) begin
                sh_d    = i_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end else if (done) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else if (accept) begin
            hd_d        = i_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hd_q        <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hd_q        <= hd_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer plus a loopback against a bit-collecting
// receiver model at widths 8, 2 and 13.
module tb_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  d8;  logic v8, r8, e8, o8, w8, l8, b8;
    logic [1:0]  d2;  logic v2, r2, e2, o2, w2, l2, b2;
    logic [12:0] d13; logic v13, r13, e13, o13, w13, l13, b13;

    serializer #(.DATA_WIDTH(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_data(d8), .i_valid(v8), .o_ready(r8),
        .i_en(e8), .o_data(o8), .o_wen(w8), .o_last(l8), .o_busy(b8));
    serializer #(.DATA_WIDTH(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_data(d2), .i_valid(v2), .o_ready(r2),
        .i_en(e2), .o_data(o2), .o_wen(w2), .o_last(l2), .o_busy(b2));
    serializer #(.DATA_WIDTH(13)) u13 (
        .i_clk(clk), .i_rst(rst), .i_data(d13), .i_valid(v13), .o_ready(r13),
        .i_en(e13), .o_data(o13), .o_wen(w13), .o_last(l13), .o_busy(b13));

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; v8 = 1'b0; e8 = 1'b1; d8 = '0;
        tick; tick;
        settle;
        n_cmp++; if ({r8, w8, b8, l8, o8} !== 5'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b want 00000", {r8, w8, b8, l8, o8});
        end
        tick;
        rst = 1'b0;
        settle;
        n_cmp++; if (r8 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", r8); end
        n_cmp++; if ({b8, w8} !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", {b8, w8}); end
    endtask

    task automatic test_single;
        logic [7:0] w;
        w = 8'hA5;
        tick;
        d8 = w; v8 = 1'b1; e8 = 1'b1;
        settle;
        n_cmp++; if (r8 !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", r8); end
        for (int k = 0; k < 8; k++) begin
            tick;
            v8 = 1'b0;
            settle;
            n_cmp++; if ({w8, o8, l8, r8} !== {1'b1, w[k], (k == 7), 1'b1}) begin
                n_err++; $display("FAIL single_bit%0d: got wen/data/last/ready %b want %b", k,
                                  {w8, o8, l8, r8}, {1'b1, w[k], (k == 7), 1'b1});
            end
        end
        tick;
        settle;
        n_cmp++; if ({b8, w8} !== 2'b00) begin n_err++; $display("FAIL single_end: got %b want 00", {b8, w8}); end
    endtask

    // Streams three words with i_valid held; words[0] is accepted first.
    task automatic stream3(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        logic [23:0] bits;
        logic [7:0]  words [3];
        logic        exp_rdy;
        int          idx;
        bits = {c, b, a};
        words[0] = a; words[1] = b; words[2] = c;
        idx = 0;
        for (int cy = 0; cy <= 25; cy++) begin
            tick;
            e8 = 1'b1;
            v8 = (idx < 3);
            d8 = (idx < 3) ? words[idx] : 8'h00;
            settle;
            if (cy >= 1 && cy <= 24) begin
                n_cmp++; if ({w8, o8, l8} !== {1'b1, bits[cy-1], ((cy % 8) == 0)}) begin
                    n_err++; $display("FAIL %s_bit%0d: got wen/data/last %b want %b", name, cy - 1,
                                      {w8, o8, l8}, {1'b1, bits[cy-1], ((cy % 8) == 0)});
                end
            end
            exp_rdy = !((cy >= 2 && cy <= 8) || (cy >= 10 && cy <= 16));
            n_cmp++; if (r8 !== exp_rdy) begin
                n_err++; $display("FAIL %s_ready_c%0d: got %b want %b", name, cy, r8, exp_rdy);
            end
            if (v8 && r8) idx++;
        end
        n_cmp++; if ({b8, w8, idx[1:0]} !== {2'b00, 2'd3}) begin
            n_err++; $display("FAIL %s_end: got busy/wen/accepts %b want 0011", name, {b8, w8, idx[1:0]});
        end
        v8 = 1'b0;
    endtask

    task automatic test_back_to_back;
        stream3("b2b", 8'h01, 8'hFF, 8'h3C);
    endtask

    task automatic test_backpressure;
        stream3("bp", 8'h11, 8'h22, 8'h77);
    endtask

    task automatic test_pacing;
        logic [7:0] w;
        int         k;
        w = 8'h96;
        tick;
        d8 = w; v8 = 1'b1; e8 = 1'b1;
        settle;
        for (int cy = 1; cy <= 16; cy++) begin
            tick;
            v8 = 1'b0;
            e8 = ((cy % 2) == 0);
            settle;
            k = (cy - 1) / 2;
            n_cmp++; if ({w8, o8, l8} !== {e8, w[k], (k == 7)}) begin
                n_err++; $display("FAIL pace_c%0d: got wen/data/last %b want %b", cy,
                                  {w8, o8, l8}, {e8, w[k], (k == 7)});
            end
        end
        tick;
        e8 = 1'b1;
        settle;
        n_cmp++; if ({b8, w8} !== 2'b00) begin n_err++; $display("FAIL pace_end: got %b want 00", {b8, w8}); end
    endtask

    task automatic test_reset_midword;
        logic [7:0] w;
        w = 8'h5A;
        tick;
        d8 = 8'hF0; v8 = 1'b1; e8 = 1'b1;
        settle;
        for (int k = 0; k < 3; k++) begin
            tick; v8 = 1'b0; settle;
        end
        tick;
        rst = 1'b1;
        settle;
        n_cmp++; if ({w8, l8, b8, r8, o8} !== 5'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got %b want 00000", {w8, l8, b8, r8, o8});
        end
        tick;
        rst = 1'b0; d8 = w; v8 = 1'b1;
        settle;
        n_cmp++; if ({r8, w8, b8} !== 3'b100) begin
            n_err++; $display("FAIL rstmid_after: got ready/wen/busy %b want 100", {r8, w8, b8});
        end
        for (int k = 0; k < 8; k++) begin
            tick; v8 = 1'b0; settle;
            n_cmp++; if ({w8, o8} !== {1'b1, w[k]}) begin
                n_err++; $display("FAIL rstmid_bit%0d: got %b want %b", k, {w8, o8}, {1'b1, w[k]});
            end
        end
        tick; settle;
    endtask

    task automatic test_loopback;
        logic [7:0]  q8[$];  logic [7:0]  rx8;
        logic [1:0]  q2[$];  logic [1:0]  rx2;
        logic [12:0] q13[$]; logic [12:0] rx13;
        int s8 = 0, s2 = 0, s13 = 0, g8 = 0, g2 = 0, g13 = 0;
        int c8 = 0, c2 = 0, c13 = 0, bad = 0;
        rx8 = '0; rx2 = '0; rx13 = '0;
        for (int cy = 0; cy < 30000 && !(g8 == 200 && g2 == 200 && g13 == 200); cy++) begin
            tick;
            v8  = (s8 < 200)  && ($urandom_range(0, 3) != 0); d8  = 8'($urandom);  e8  = 1'($urandom_range(0, 1));
            v2  = (s2 < 200)  && ($urandom_range(0, 3) != 0); d2  = 2'($urandom);  e2  = 1'($urandom_range(0, 1));
            v13 = (s13 < 200) && ($urandom_range(0, 3) != 0); d13 = 13'($urandom); e13 = 1'($urandom_range(0, 1));
            settle;
            if (v8 && r8)   begin q8.push_back(d8);   s8++;  end
            if (v2 && r2)   begin q2.push_back(d2);   s2++;  end
            if (v13 && r13) begin q13.push_back(d13); s13++; end
            if (w8) begin
                rx8 = {o8, rx8[7:1]};
                if (++c8 == 8) begin
                    c8 = 0; g8++; n_cmp++;
                    if (q8.size() == 0 || rx8 !== q8[0] || l8 !== 1'b1) begin
                        n_err++; bad++;
                        if (bad < 10) $display("FAIL loop8_word%0d: got %h last %b want %h", g8, rx8, l8,
                                               (q8.size() != 0) ? q8[0] : 8'h00);
                    end
                    if (q8.size() != 0) void'(q8.pop_front());
                end
            end
            if (w2) begin
                rx2 = {o2, rx2[1]};
                if (++c2 == 2) begin
                    c2 = 0; g2++; n_cmp++;
                    if (q2.size() == 0 || rx2 !== q2[0] || l2 !== 1'b1) begin
                        n_err++; bad++;
                        if (bad < 10) $display("FAIL loop2_word%0d: got %h last %b want %h", g2, rx2, l2,
                                               (q2.size() != 0) ? q2[0] : 2'h0);
                    end
                    if (q2.size() != 0) void'(q2.pop_front());
                end
            end
            if (w13) begin
                rx13 = {o13, rx13[12:1]};
                if (++c13 == 13) begin
                    c13 = 0; g13++; n_cmp++;
                    if (q13.size() == 0 || rx13 !== q13[0] || l13 !== 1'b1) begin
                        n_err++; bad++;
                        if (bad < 10) $display("FAIL loop13_word%0d: got %h last %b want %h", g13, rx13, l13,
                                               (q13.size() != 0) ? q13[0] : 13'h0);
                    end
                    if (q13.size() != 0) void'(q13.pop_front());
                end
            end
        end
        v8 = 1'b0; v2 = 1'b0; v13 = 1'b0;
        n_cmp++; if (g8 !== 200 || g2 !== 200 || g13 !== 200) begin
            n_err++; $display("FAIL loop_counts: got %0d/%0d/%0d words want 200/200/200", g8, g2, g13);
        end
    endtask

    initial begin
        rst = 1'b1;
        d8 = '0; v8 = 1'b0; e8 = 1'b0;
        d2 = '0; v2 = 1'b0; e2 = 1'b0;
        d13 = '0; v13 = 1'b0; e13 = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_pacing;
        test_reset_midword;
        test_backpressure;
        test_loopback;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
